// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS CPU: HI/LO multiply/divide unit
// op codes, FSM states and iteration count.
package mips_cpu_pkg;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SIGN,
    ST_DONE
  } muldiv_state_t;

endpackage

// File: rtl/mips_cpu_muldiv_datapath.sv
// Iterative mul/div datapath: 64-bit shift register, 33-bit add/sub,
// sign-fix negator. Ports: load/skip/step controls, op info in, hi/lo result out.
import mips_cpu_pkg::*;

module mips_cpu_muldiv_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        skip,
  input  logic        step,
  input  logic        div,
  input  logic        a_neg,
  input  logic        b_neg,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic [63:0] acc;
  logic [31:0] opb;
  logic        dv_q;
  logic        neg_res;
  logic        neg_rem;
  logic        div0;

  logic [32:0] x;
  logic [32:0] y;
  logic [32:0] sum;
  logic        ge;
  logic [63:0] nxt;
  logic [63:0] neg64;

  // Mult: {hi,lo} = partial product / multiplier.
  // Div : {hi,lo} = partial remainder / quotient (restoring).
  always_comb begin
    y  = {1'b0, opb};
    x  = dv_q ? acc[63:31] : {1'b0, acc[63:32]};
    sum = dv_q ? (x - y) : (x + y);
    ge  = (x >= y);
    nxt = acc;
    if (dv_q) begin
      if (ge) nxt = {sum[31:0], acc[30:0], 1'b1};
      else    nxt = {x[31:0], acc[30:0], 1'b0};
    end else begin
      if (acc[0]) nxt = {sum, acc[31:1]};
      else        nxt = {1'b0, acc[63:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opb     <= '0;
      dv_q    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (load) begin
      opb     <= b_mag;
      dv_q    <= div;
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= (b_mag == '0);
      // Early-out preloads what 32 steps would have produced.
      if (skip) acc <= div ? {a_mag, 32'hFFFF_FFFF} : 64'd0;
      else      acc <= {32'd0, a_mag};
    end else if (step) begin
      acc <= nxt;
    end
  end

  assign neg64 = ~acc + 64'd1;

  always_comb begin
    res_hi = acc[63:32];
    res_lo = acc[31:0];
    if (dv_q) begin
      if (neg_rem) res_hi = ~acc[63:32] + 32'd1;
      if (div0)         res_lo = 32'hFFFF_FFFF;
      else if (neg_res) res_lo = ~acc[31:0] + 32'd1;
    end else if (neg_res) begin
      res_hi = neg64[63:32];
      res_lo = neg64[31:0];
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// HI/LO multiply-divide unit: FSM, counter, HI/LO and MTHI/MTLO.
// In: start/op/a/b, hi_we/lo_we/wdata. Out: busy, done, hi, lo. Option: MIPS_CPU_MULDIV_EARLY_OUT_EN.
import mips_cpu_pkg::*;

module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  muldiv_state_t state;
  muldiv_op_t    mop;
  logic [4:0]    cnt;
  logic          sgn;
  logic          dv;
  logic          a_neg;
  logic          b_neg;
  logic [31:0]   a_mag;
  logic [31:0]   b_mag;
  logic          skip;
  logic          load;
  logic          step;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  assign mop = muldiv_op_t'(op);

  always_comb begin
    sgn = 1'b0;
    dv  = 1'b0;
    unique case (mop)
      OP_MULT:  sgn = 1'b1;
      OP_MULTU: sgn = 1'b0;
      OP_DIV:   begin sgn = 1'b1; dv = 1'b1; end
      OP_DIVU:  dv = 1'b1;
      default:  dv = 1'b0;
    endcase
  end

  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];
  assign a_mag = a_neg ? (~a + 32'd1) : a;
  assign b_mag = b_neg ? (~b + 32'd1) : b;

`ifdef MIPS_CPU_MULDIV_EARLY_OUT_EN
  assign skip = dv ? (b == '0) : ((a == '0) || (b == '0));
`else
  assign skip = 1'b0;
`endif

  assign load = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign step = (state == ST_CALC);

  mips_cpu_muldiv_datapath u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .skip   (skip),
    .step   (step),
    .div    (dv),
    .a_neg  (a_neg),
    .b_neg  (b_neg),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (!busy && hi_we) hi <= wdata;
      if (!busy && lo_we) lo <= wdata;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= skip ? ST_SIGN : ST_CALC;
            cnt   <= skip ? 5'd0 : 5'(MULDIV_ITERS - 1);
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          cnt <= cnt - 5'd1;
          if (cnt == '0) state <= ST_SIGN;
        end
        ST_SIGN: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          hi    <= res_hi;
          lo    <= res_lo;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: directed cases,
// MTHI/MTLO, abort by reset, random ops vs arithmetic model.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_cpu_muldiv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: r = 64'(sx * sy);
      2'd1: r = {32'd0, x} * {32'd0, y};
      2'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
    endcase
    return r;
  endfunction

  function automatic int exp_cycles(input logic [1:0] o,
                                    input logic [31:0] x,
                                    input logic [31:0] y);
`ifdef MIPS_CPU_MULDIV_EARLY_OUT_EN
    if (o[1] ? (y == 0) : (x == 0 || y == 0)) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom());
    endcase
  endfunction

  // Accept edge counts as cycle 1; returns cycle where done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, output int cyc);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h want all 0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int cyc;
    logic [1:0] ops [5];
    logic [31:0] xs [5];
    logic [31:0] ys [5];
    logic [63:0] want [5];
    ops[0] = 2'd1; xs[0] = 32'hFFFF_FFFF; ys[0] = 32'hFFFF_FFFF;
    want[0] = 64'hFFFF_FFFE_0000_0001;
    ops[1] = 2'd0; xs[1] = 32'hFFFF_FFFD; ys[1] = 32'd5;
    want[1] = 64'hFFFF_FFFF_FFFF_FFF1;
    ops[2] = 2'd2; xs[2] = 32'hFFFF_FFF9; ys[2] = 32'd2;
    want[2] = 64'hFFFF_FFFF_FFFF_FFFD;
    ops[3] = 2'd3; xs[3] = 32'd7; ys[3] = 32'd0;
    want[3] = 64'h0000_0007_FFFF_FFFF;
    ops[4] = 2'd2; xs[4] = 32'h8000_0000; ys[4] = 32'hFFFF_FFFF;
    want[4] = 64'h0000_0000_8000_0000;
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], xs[i], ys[i], cyc);
      checks++;
      if ({hi, lo} !== want[i] || cyc != exp_cycles(ops[i], xs[i], ys[i])
          || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed%0d: hi=%h lo=%h cyc=%0d busy=%b want %h cyc=%0d busy=0",
                 i, hi, lo, cyc, busy, want[i], exp_cycles(ops[i], xs[i], ys[i]));
      end
    end
  endtask

  task automatic test_mtx();
    int pulses;
    int n;
    @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk); #1; hi_we = 1'b0;
    checks++;
    if (hi !== 32'h1234) begin
      errors++; $display("FAIL mthi: hi=%h want 00001234", hi);
    end
    @(negedge clk); lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk); #1; lo_we = 1'b0;
    checks++;
    if (lo !== 32'h5678) begin
      errors++; $display("FAIL mtlo: lo=%h want 00005678", lo);
    end
    // Second start and MTLO while busy must be dropped.
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'd100; b = 32'd3;
    lo_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #1; start = 1'b0; lo_we = 1'b0;
    checks++;
    if (lo !== 32'h5678 || busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore: lo=%h busy=%b want 00005678 1", lo, busy);
    end
    pulses = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || lo !== 32'd42 || hi !== 32'd0) begin
      errors++;
      $display("FAIL one_done: pulses=%0d hi=%h lo=%h want 1 0 2a",
               pulses, hi, lo);
    end
    // MTHI coinciding with start: write lands, result later overwrites.
    @(negedge clk);
    start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd5;
    hi_we = 1'b1; wdata = 32'hABCD;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    checks++;
    if (hi !== 32'hABCD || busy !== 1'b1) begin
      errors++;
      $display("FAIL coincide_wr: hi=%h busy=%b want 0000abcd 1", hi, busy);
    end
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd15) begin
      errors++;
      $display("FAIL coincide_res: hi=%h lo=%h want 0 f", hi, lo);
    end
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk); start = 1'b1; op = 2'd1; a = 32'd6; b = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               busy, done, hi, lo);
    end
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL abort_nodone: pulses=%0d hi=%h lo=%h want 0 0 0",
               pulses, hi, lo);
    end
    do_op(2'd1, 32'd6, 32'd7, cyc);
    checks++;
    if (lo !== 32'd42 || hi !== 32'd0 || cyc != 34) begin
      errors++;
      $display("FAIL after_reset: hi=%h lo=%h cyc=%0d want 0 2a 34",
               hi, lo, cyc);
    end
  endtask

  // Consecutive calls start each op while the previous sits in DONE.
  task automatic test_back_to_back();
    int cyc;
    logic [1:0] o;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] want;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      want = model(o, x, y);
      do_op(o, x, y, cyc);
      checks++;
      if ({hi, lo} !== want || cyc != exp_cycles(o, x, y)) begin
        errors++;
        $display("FAIL rand%0d op=%0d a=%h b=%h: hi=%h lo=%h cyc=%0d want %h cyc=%0d",
                 i, o, x, y, hi, lo, cyc, want, exp_cycles(o, x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mtx();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
